// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the two-requester memory port.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-priority arbiter for one single-cycle memory port with fetch anti-starvation.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       starved, if_gnt, d_gnt, rsp_if, rsp_d;

    always_comb begin
        starved  = bus.if_req && (starve_q == LIMIT);
        if_gnt   = reset && bus.if_req && (!bus.d_req || starved);
        d_gnt    = reset && bus.d_req && !starved;
        state_d  = if_gnt ? BUSY_IF : d_gnt ? BUSY_D : IDLE;
        // Any cycle without a waiting fetch, or a fetch grant, ends the starvation window.
        starve_d = (!bus.if_req || if_gnt) ? 4'd0
                 : (d_gnt && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
        // Responses are gated by reset so an access in flight at reset is discarded.
        rsp_if   = reset && (state_q == BUSY_IF);
        rsp_d    = reset && (state_q == BUSY_D);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_req   = if_gnt || d_gnt;
    assign bus.mem_addr  = d_gnt ? bus.d_addr : if_gnt ? bus.if_addr : 32'd0;
    assign bus.mem_we    = d_gnt ? bus.d_we : 4'd0;
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : 32'd0;
    assign bus.if_rvalid = rsp_if;
    assign bus.if_rdata  = rsp_if ? bus.mem_rdata : 32'd0;
    assign bus.d_rvalid  = rsp_d;
    assign bus.d_rdata   = rsp_d ? bus.mem_rdata : 32'd0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                          input logic [3:0] we, input logic [31:0] wd, input logic [31:0] rd);
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.d_req     = dr;
        bus.d_addr    = da;
        bus.d_we      = we;
        bus.d_wdata   = wd;
        bus.mem_rdata = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(1, 32'h40, 1, 32'h80, 4'hF, 32'h1234, 32'h55);
        #1;
        checks++; if (bus.if_gnt !== 1'b0) begin fails++; $display("FAIL reset_if_gnt got %b want 0", bus.if_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin fails++; $display("FAIL reset_d_gnt got %b want 0", bus.d_gnt); end
        checks++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 4'h0) begin fails++; $display("FAIL reset_mem_we got %h want 0", bus.mem_we); end
        @(negedge clk);
        #1;
        checks++; if (dut.starve_q !== 4'd0) begin fails++; $display("FAIL reset_starve got %0d want 0", dut.starve_q); end
        checks++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0)
            begin fails++; $display("FAIL reset_rvalid got %b%b want 00", bus.if_rvalid, bus.d_rvalid); end
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fetch_only();
        do_reset();
        @(negedge clk);
        set_in(1, 32'h100, 0, 0, 0, 0, 0);
        #1;
        checks++; if (bus.if_gnt !== 1'b1) begin fails++; $display("FAIL fetch_gnt got %b want 1", bus.if_gnt); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 4'h0)
            begin fails++; $display("FAIL fetch_bus got req=%b addr=%h we=%h want 1/100/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h13);
        #1;
        checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h13)
            begin fails++; $display("FAIL fetch_rsp got v=%b d=%h want 1/00000013", bus.if_rvalid, bus.if_rdata); end
        checks++; if (bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_d_rvalid got %b want 0", bus.d_rvalid); end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        set_in(1, 32'h200, 1, 32'h2000, 4'hF, 32'hDEADBEEF, 0);
        #1;
        checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0)
            begin fails++; $display("FAIL cont_gnt got d=%b if=%b want 1/0", bus.d_gnt, bus.if_gnt); end
        checks++; if (bus.mem_addr !== 32'h2000 || bus.mem_we !== 4'hF || bus.mem_wdata !== 32'hDEADBEEF)
            begin fails++; $display("FAIL cont_bus got %h/%h/%h want 2000/f/deadbeef", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'hA5A5);
        #1;
        checks++; if (bus.d_rvalid !== 1'b1 || bus.if_rvalid !== 1'b0)
            begin fails++; $display("FAIL cont_rsp got d=%b if=%b want 1/0", bus.d_rvalid, bus.if_rvalid); end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            set_in(1, 32'h300, 1, 32'h3000, 4'h0, 0, 0);
            #1;
            checks++; if (dut.starve_q !== 4'((c <= 5) ? c - 1 : 0))
                begin fails++; $display("FAIL starve_cnt c%0d got %0d want %0d", c, dut.starve_q, (c <= 5) ? c - 1 : 0); end
            checks++; if (bus.if_gnt !== (c == 5) || bus.d_gnt !== (c != 5))
                begin fails++; $display("FAIL starve_gnt c%0d got if=%b d=%b want if=%b", c, bus.if_gnt, bus.d_gnt, c == 5); end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            rd = $urandom;
            set_in(c <= 3, 32'(4 * (c - 1)), 0, 0, 0, 0, rd);
            #1;
            checks++; if (bus.if_gnt !== (c <= 3) || (c <= 3 && bus.mem_addr !== 32'(4 * (c - 1))))
                begin fails++; $display("FAIL b2b_gnt c%0d got gnt=%b addr=%h", c, bus.if_gnt, bus.mem_addr); end
            checks++; if (bus.if_rvalid !== (c >= 2) || bus.if_rdata !== ((c >= 2) ? rd : 32'd0))
                begin fails++; $display("FAIL b2b_rsp c%0d got v=%b d=%h want v=%b d=%h", c, bus.if_rvalid, bus.if_rdata, c >= 2, rd); end
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        @(negedge clk);
        set_in(0, 0, 1, 32'h4000, 4'h0, 0, 0);
        #1;
        checks++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL midrst_gnt got %b want 1", bus.d_gnt); end
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'h77);
        #1;
        checks++; if (bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL midrst_rv1 got %b want 0", bus.d_rvalid); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.d_rvalid !== 1'b0 || bus.mem_req !== 1'b0 || dut.starve_q !== 4'd0)
            begin fails++; $display("FAIL midrst_rv2 got rv=%b req=%b cnt=%0d want 0/0/0", bus.d_rvalid, bus.mem_req, dut.starve_q); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            set_in(0, 32'hFFFF, 0, 32'hEEEE, 4'hF, 32'h1, $urandom);
            #1;
            checks++; if ({bus.mem_req, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid} !== 5'b0 || bus.mem_addr !== 32'd0
                           || bus.mem_we !== 4'd0 || bus.mem_wdata !== 32'd0 || dut.starve_q !== 4'd0)
                begin fails++; $display("FAIL idle c%0d got req=%b addr=%h cnt=%0d", c, bus.mem_req, bus.mem_addr, dut.starve_q); end
        end
    endtask

    task automatic test_random();
        int          cnt = 0;
        int          pend = 0;
        logic        ir = 0, dr = 0, ih = 0, dh = 0, eig, edg;
        logic [31:0] ia = 0, da = 0, wd = 0, rd;
        logic [3:0]  we = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 59) != 0);
            if (!ih) begin ir = $urandom_range(0, 2) != 0; ia = $urandom; end
            if (!dh) begin dr = $urandom_range(0, 2) != 0; da = $urandom; we = $urandom; wd = $urandom; end
            rd = $urandom;
            set_in(ir, ia, dr, da, we, wd, rd);
            #1;
            eig = reset && ir && (!dr || cnt == LIM);
            edg = reset && dr && !eig;
            checks++; if (bus.if_gnt !== eig || bus.d_gnt !== edg || bus.mem_req !== (eig || edg))
                begin fails++; $display("FAIL rnd_gnt c%0d got if=%b d=%b req=%b want %b/%b", c, bus.if_gnt, bus.d_gnt, bus.mem_req, eig, edg); end
            checks++; if (bus.mem_addr !== (edg ? da : eig ? ia : 32'd0) || bus.mem_we !== (edg ? we : 4'd0)
                           || bus.mem_wdata !== (edg ? wd : 32'd0))
                begin fails++; $display("FAIL rnd_bus c%0d got %h/%h/%h", c, bus.mem_addr, bus.mem_we, bus.mem_wdata); end
            checks++; if (bus.if_rvalid !== (reset && pend == 1) || bus.if_rdata !== ((reset && pend == 1) ? rd : 32'd0)
                           || bus.d_rvalid !== (reset && pend == 2) || bus.d_rdata !== ((reset && pend == 2) ? rd : 32'd0))
                begin fails++; $display("FAIL rnd_rsp c%0d got if=%b d=%b pend=%0d", c, bus.if_rvalid, bus.d_rvalid, pend); end
            if (!reset) begin
                pend = 0; cnt = 0; ih = 0; dh = 0;
            end else begin
                pend = eig ? 1 : edg ? 2 : 0;
                cnt  = (!ir || eig) ? 0 : edg ? ((cnt + 1 > LIM) ? LIM : cnt + 1) : cnt;
                ih   = ir && !eig && ($urandom_range(0, 9) != 0);
                dh   = dr && !edg && ($urandom_range(0, 9) != 0);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_back_to_back();
        test_reset_mid_op();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, max consecutive data grants while a fetch waits (legal 1..15).
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: if_req  in  1  fetch request; if_addr  in  32  fetch address.
REQ-005 SHALL have ports: if_gnt  out  1  fetch accepted this cycle; if_rvalid  out  1  fetch data valid; if_rdata  out  32  fetch data.
REQ-006 SHALL have ports: d_req  in  1  data request; d_addr  in  32  data address; d_we  in  4  byte write-enables (0 = load); d_wdata  in  32  store data.
REQ-007 SHALL have ports: d_gnt  out  1  data accepted; d_rvalid  out  1  load data valid / store complete; d_rdata  out  32  load data.
REQ-008 SHALL have ports: mem_req  out  1; mem_addr  out  32; mem_we  out  4; mem_wdata  out  32; mem_rdata  in  32, valid exactly 1 cycle after mem_req.

Function
REQ-009 SHALL use a 3-state FSM: IDLE (no access outstanding), BUSY_IF (fetch response due this cycle), BUSY_D (data response due this cycle).
REQ-010 SHALL arbitrate every cycle in every state; at most one grant per cycle; a grant drives mem_req=1 combinationally in the same cycle.
REQ-011 SHALL grant data over fetch when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
REQ-012 SHALL drive mem_addr/mem_we/mem_wdata from the granted requester; fetch grant forces mem_we=4'b0000 and mem_wdata=0.
REQ-013 SHALL drive mem_req=0, mem_addr=0, mem_we=0, mem_wdata=0 when no grant.
REQ-014 SHALL transition next state to BUSY_IF on fetch grant, BUSY_D on data grant, IDLE on no grant.
REQ-015 SHALL assert if_rvalid=1 in BUSY_IF and d_rvalid=1 in BUSY_D, for exactly one cycle, with *_rdata = mem_rdata; otherwise *_rvalid=0 and *_rdata=0.
REQ-016 SHALL return d_rvalid for stores (d_we != 0) as a completion ack; d_rdata is mem_rdata, undefined content.
REQ-017 SHALL sustain one grant per cycle (response of access N and grant of access N+1 in the same cycle).
REQ-018 SHALL keep a 4-bit starve_cnt: +1 on each data grant while if_req=1; cleared to 0 on fetch grant or any cycle with if_req=0; saturates at STARVE_LIMIT.
REQ-019 SHALL require requesters to hold *_req and request fields stable until *_gnt; a request deasserted before grant is dropped with no response.
REQ-020 SHALL never assert if_gnt and d_gnt in the same cycle, nor if_rvalid and d_rvalid in the same cycle.

Reset
REQ-021 SHALL, while reset=0 at a rising edge, set state=IDLE and starve_cnt=0.
REQ-022 SHALL force if_gnt, d_gnt, mem_req, mem_we to 0 combinationally while reset=0.
REQ-023 SHALL discard an outstanding access when reset is applied mid-operation: no *_rvalid in the cycle after reset deasserts.

Verification
REQ-024 Fetch only: if_req=1, if_addr=0x100, mem_rdata=0x00000013 next cycle -> if_gnt=1, mem_addr=0x100, mem_we=0; next cycle if_rvalid=1, if_rdata=0x00000013.
REQ-025 Contention: if_req=1 and d_req=1 (d_addr=0x2000, d_we=4'b1111, d_wdata=0xDEADBEEF) -> d_gnt=1, mem_we=4'b1111, mem_wdata=0xDEADBEEF, if_gnt=0; next cycle d_rvalid=1.
REQ-026 Starvation: STARVE_LIMIT=4, if_req and d_req held 1 -> d_gnt cycles 1-4, if_gnt cycle 5, starve_cnt=0 after, d_gnt cycle 6.
REQ-027 Back-to-back: fetches to 0x0,0x4,0x8 on 3 consecutive cycles -> if_gnt=1 each cycle, if_rvalid=1 cycles 2-4 with matching mem_rdata.
REQ-028 Reset mid-op: grant data load at cycle N, reset=0 at cycle N+1 -> d_rvalid=0 at N+1 and N+2, state=IDLE, mem_req=0.
REQ-029 Idle: no requests for 10 cycles -> mem_req=0, mem_addr=0, all gnt/rvalid=0, starve_cnt=0.
